// File: rtl/multicycle_control_if.sv
// Control bundle between the multicycle MIPS main FSM and its datapath.
// master = control FSM, slave = datapath.
interface multicycle_control_if;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic [2:0] alu_op;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] pc_source;
  logic       pc_write;
  logic       ir_write;
  logic       iord;
  logic       mem_read;
  logic       mem_write;
  logic       reg_write;
  logic [1:0] reg_dst;
  logic [1:0] mem_to_reg;
  logic       instr_retired;
  logic [1:0] err_code;

  modport master (
    input  opcode, zero, mem_ready,
    output alu_op, alu_src_a, alu_src_b, pc_source, pc_write, ir_write, iord,
           mem_read, mem_write, reg_write, reg_dst, mem_to_reg, instr_retired, err_code
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  alu_op, alu_src_a, alu_src_b, pc_source, pc_write, ir_write, iord,
           mem_read, mem_write, reg_write, reg_dst, mem_to_reg, instr_retired, err_code
  );
endinterface

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle MIPS datapath: fetch/decode/execute/memory/write-back
// sequencing with memory-ready waits and a sticky error trap (illegal opcode, memory timeout).
module multicycle_control #(
  parameter int TIMEOUT = 16
) (
  input logic                 clk,
  input logic                 reset,
  multicycle_control_if.master bus
);
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] WAIT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_JAL  = 6'h03;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_LUI  = 6'h0F;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_READ, S_MEM_WB, S_MEM_WRITE,
    S_EXEC_R, S_EXEC_I, S_ALU_WB, S_BRANCH, S_JUMP, S_ERROR
  } state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] wait_cnt_reg, wait_cnt_next;
  logic [1:0]    err_code_reg, err_code_next;
  logic [5:0]    opcode_reg, opcode_next;
  logic [2:0]    exec_alu_op;
  logic          is_wait;
  logic          timeout_hit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= S_IDLE;
      wait_cnt_reg <= '0;
      err_code_reg <= 2'b00;
      opcode_reg   <= '0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      err_code_reg <= err_code_next;
      opcode_reg   <= opcode_next;
    end
  end

  always_comb begin
    state_next        = state_reg;
    err_code_next     = err_code_reg;
    opcode_next       = opcode_reg;
    wait_cnt_next     = wait_cnt_reg;
    exec_alu_op       = 3'b000;
    bus.alu_op        = 3'b000;
    bus.alu_src_a     = 1'b0;
    bus.alu_src_b     = 2'b00;
    bus.pc_source     = 2'b00;
    bus.pc_write      = 1'b0;
    bus.ir_write      = 1'b0;
    bus.iord          = 1'b0;
    bus.mem_read      = 1'b0;
    bus.mem_write     = 1'b0;
    bus.reg_write     = 1'b0;
    bus.reg_dst       = 2'b00;
    bus.mem_to_reg    = 2'b00;
    bus.instr_retired = 1'b0;
    bus.err_code      = err_code_reg;

    case (opcode_reg)
      OP_R:    exec_alu_op = 3'b111;
      OP_ADDI: exec_alu_op = 3'b100;
      OP_ORI:  exec_alu_op = 3'b101;
      OP_LUI:  exec_alu_op = 3'b110;
      default: exec_alu_op = 3'b000;
    endcase

    is_wait     = (state_reg == S_FETCH) || (state_reg == S_MEM_READ) || (state_reg == S_MEM_WRITE);
    timeout_hit = (TIMEOUT != 0) && is_wait && !bus.mem_ready && (wait_cnt_reg == WAIT_LAST);

    case (state_reg)
      S_IDLE: state_next = S_FETCH;
      S_FETCH: begin
        bus.mem_read  = 1'b1;
        bus.alu_src_b = 2'b01;
        bus.alu_op    = 3'b010;
        bus.ir_write  = bus.mem_ready;
        bus.pc_write  = bus.mem_ready;
        if (bus.mem_ready) state_next = S_DECODE;
      end
      S_DECODE: begin
        // Branch target is computed here speculatively; the opcode is captured for later states.
        bus.alu_src_b = 2'b11;
        bus.alu_op    = 3'b010;
        opcode_next   = bus.opcode;
        case (bus.opcode)
          OP_LW, OP_SW:             state_next = S_MEM_ADDR;
          OP_R:                     state_next = S_EXEC_R;
          OP_ADDI, OP_ORI, OP_LUI:  state_next = S_EXEC_I;
          OP_BEQ, OP_BNE:           state_next = S_BRANCH;
          OP_J, OP_JAL:             state_next = S_JUMP;
          default: begin
            state_next    = S_ERROR;
            err_code_next = 2'b01;
          end
        endcase
      end
      S_MEM_ADDR: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
        bus.alu_op    = 3'b010;
        state_next    = (opcode_reg == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      end
      S_MEM_READ: begin
        bus.mem_read = 1'b1;
        bus.iord     = 1'b1;
        if (bus.mem_ready) state_next = S_MEM_WB;
      end
      S_MEM_WB: begin
        bus.reg_write     = 1'b1;
        bus.mem_to_reg    = 2'b01;
        bus.instr_retired = 1'b1;
        state_next        = S_FETCH;
      end
      S_MEM_WRITE: begin
        bus.mem_write     = 1'b1;
        bus.iord          = 1'b1;
        bus.instr_retired = bus.mem_ready;
        if (bus.mem_ready) state_next = S_FETCH;
      end
      S_EXEC_R, S_EXEC_I: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = (state_reg == S_EXEC_R) ? 2'b00 : 2'b10;
        bus.alu_op    = exec_alu_op;
        state_next    = S_ALU_WB;
      end
      S_ALU_WB: begin
        bus.reg_write     = 1'b1;
        bus.reg_dst       = (opcode_reg == OP_R) ? 2'b01 : 2'b00;
        bus.alu_op        = exec_alu_op;
        bus.instr_retired = 1'b1;
        state_next        = S_FETCH;
      end
      S_BRANCH: begin
        bus.alu_src_a     = 1'b1;
        bus.alu_op        = 3'b011;
        bus.pc_source     = 2'b01;
        bus.pc_write      = (opcode_reg == OP_BEQ) ? bus.zero : !bus.zero;
        bus.instr_retired = 1'b1;
        state_next        = S_FETCH;
      end
      S_JUMP: begin
        bus.pc_source     = 2'b10;
        bus.pc_write      = 1'b1;
        bus.instr_retired = 1'b1;
        if (opcode_reg == OP_JAL) begin
          bus.reg_write  = 1'b1;
          bus.reg_dst    = 2'b10;
          bus.mem_to_reg = 2'b10;
        end
        state_next = S_FETCH;
      end
      S_ERROR: state_next = S_ERROR;
      default: state_next = S_ERROR;
    endcase

    // A ready in the last allowed wait cycle still completes the access.
    if (timeout_hit) begin
      state_next    = S_ERROR;
      err_code_next = 2'b10;
    end

    if (state_next != state_reg)
      wait_cnt_next = '0;
    else if (is_wait && !bus.mem_ready && TIMEOUT != 0)
      wait_cnt_next = wait_cnt_reg + CW'(1);
  end
endmodule

// File: tb/tb_multicycle_control.sv
// Randomized self-checking bench for multicycle_control: an instruction-level model emits
// the expected per-cycle control vector for each instruction, memory wait pattern and error case.
module tb_multicycle_control;
  typedef struct packed {
    logic [2:0] alu_op;
    logic       src_a;
    logic [1:0] src_b;
    logic [1:0] pc_src;
    logic       pc_write;
    logic       ir_write;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       retired;
    logic [1:0] err;
  } ctl_t;

  localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04, OP_BNE = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08, OP_ORI = 6'h0D, OP_LUI = 6'h0F, OP_LW = 6'h23, OP_SW = 6'h2B;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  bit         sel;
  int         timeout_cfg;
  int         checks = 0;
  int         errors = 0;
  ctl_t       obs_a, obs_b, obs;
  logic [5:0] ops [10];

  always #5 clk = ~clk;

  multicycle_control_if ifa ();
  multicycle_control_if ifb ();

  assign ifa.opcode = opcode;
  assign ifa.zero = zero;
  assign ifa.mem_ready = mem_ready;
  assign ifb.opcode = opcode;
  assign ifb.zero = zero;
  assign ifb.mem_ready = mem_ready;

  multicycle_control #(.TIMEOUT(16)) dut_a (.clk(clk), .reset(reset), .bus(ifa.master));
  multicycle_control #(.TIMEOUT(4))  dut_b (.clk(clk), .reset(reset), .bus(ifb.master));

  assign obs_a = {ifa.alu_op, ifa.alu_src_a, ifa.alu_src_b, ifa.pc_source, ifa.pc_write, ifa.ir_write,
                  ifa.iord, ifa.mem_read, ifa.mem_write, ifa.reg_write, ifa.reg_dst, ifa.mem_to_reg,
                  ifa.instr_retired, ifa.err_code};
  assign obs_b = {ifb.alu_op, ifb.alu_src_a, ifb.alu_src_b, ifb.pc_source, ifb.pc_write, ifb.ir_write,
                  ifb.iord, ifb.mem_read, ifb.mem_write, ifb.reg_write, ifb.reg_dst, ifb.mem_to_reg,
                  ifb.instr_retired, ifb.err_code};
  assign obs = sel ? obs_b : obs_a;

  task automatic check_ctl(input string tag, input ctl_t got, input ctl_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b required %b (op=%h t=%0t)", tag, got, exp, opcode, $time);
    end
  endtask

  task automatic cycle(input string tag, input logic rdy, input ctl_t exp);
    @(negedge clk);
    mem_ready = rdy;
    #2;
    check_ctl(tag, obs, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1 reset = 1'b0;
    #1 check_ctl("reset_async", obs, '0);
    @(negedge clk);
    #1 reset = 1'b1;
    #1 check_ctl("idle", obs, '0);
  endtask

  task automatic go_error(input logic [1:0] code, input int n);
    ctl_t e;
    e = '0;
    e.err = code;
    for (int i = 0; i < n; i++) begin
      opcode = 6'($urandom_range(0, 63));
      cycle("error_hold", 1'($urandom_range(0, 1)), e);
    end
    do_reset();
  endtask

  // kind: 0 instruction fetch, 1 load data read, 2 store write; w = cycles with mem_ready low
  task automatic wait_phase(input int kind, input int w, input int abort_at, output bit failed);
    ctl_t  e;
    logic  rdy;
    string tag;
    failed = 1'b0;
    tag = (kind == 0) ? "fetch" : (kind == 1) ? "mem_read" : "mem_write";
    for (int i = 0; i < 1000; i++) begin
      if (timeout_cfg != 0 && i == timeout_cfg) begin
        go_error(2'b10, 4);
        failed = 1'b1;
        return;
      end
      rdy = (i == w);
      e = '0;
      e.iord = (kind != 0);
      e.mem_read = (kind != 2);
      e.mem_write = (kind == 2);
      if (kind == 0) begin
        e.alu_op = 3'b010;
        e.src_b = 2'b01;
        e.ir_write = rdy;
        e.pc_write = rdy;
      end
      if (kind == 2) e.retired = rdy;
      cycle(tag, rdy, e);
      if (i == abort_at) begin
        do_reset();
        failed = 1'b1;
        return;
      end
      if (rdy) return;
    end
  endtask

  task automatic run_instr(input logic [5:0] op, input logic z, input int wf, input int wm, input int abort_at);
    bit   f;
    ctl_t e;
    wait_phase(0, wf, -1, f);
    if (f) return;
    @(negedge clk);
    opcode = op;
    zero = z;
    mem_ready = 1'($urandom_range(0, 1));
    #2;
    e = '0;
    e.alu_op = 3'b010;
    e.src_b = 2'b11;
    check_ctl("decode", obs, e);
    e = '0;
    case (op)
      OP_LW, OP_SW: begin
        e.src_a = 1'b1; e.src_b = 2'b10; e.alu_op = 3'b010;
        cycle("mem_addr", 1'($urandom_range(0, 1)), e);
        if (op == OP_LW) begin
          wait_phase(1, wm, -1, f);
          if (f) return;
          e = '0; e.reg_write = 1'b1; e.mem_to_reg = 2'b01; e.retired = 1'b1;
          cycle("mem_wb", 1'($urandom_range(0, 1)), e);
        end else begin
          wait_phase(2, wm, abort_at, f);
        end
      end
      OP_R, OP_ADDI, OP_ORI, OP_LUI: begin
        e.alu_op = (op == OP_R) ? 3'b111 : (op == OP_ADDI) ? 3'b100 : (op == OP_ORI) ? 3'b101 : 3'b110;
        e.src_a = 1'b1;
        e.src_b = (op == OP_R) ? 2'b00 : 2'b10;
        cycle("execute", 1'($urandom_range(0, 1)), e);
        e.src_a = 1'b0; e.src_b = 2'b00;
        e.reg_write = 1'b1; e.retired = 1'b1;
        e.reg_dst = (op == OP_R) ? 2'b01 : 2'b00;
        cycle("alu_wb", 1'($urandom_range(0, 1)), e);
      end
      OP_BEQ, OP_BNE: begin
        e.src_a = 1'b1; e.alu_op = 3'b011; e.pc_src = 2'b01; e.retired = 1'b1;
        e.pc_write = (op == OP_BEQ) ? z : !z;
        cycle("branch", 1'($urandom_range(0, 1)), e);
      end
      OP_J, OP_JAL: begin
        e.pc_src = 2'b10; e.pc_write = 1'b1; e.retired = 1'b1;
        if (op == OP_JAL) begin
          e.reg_write = 1'b1; e.reg_dst = 2'b10; e.mem_to_reg = 2'b10;
        end
        cycle("jump", 1'($urandom_range(0, 1)), e);
      end
      default: go_error(2'b01, 20);
    endcase
  endtask

  task automatic run_random(input int n, input int max_wait);
    logic [5:0] op;
    int wf, wm;
    for (int k = 0; k < n; k++) begin
      op = ($urandom_range(0, 15) == 0) ? 6'($urandom_range(0, 63)) : ops[$urandom_range(0, 9)];
      wf = ($urandom_range(0, 19) == 0) ? 30 : $urandom_range(0, max_wait);
      wm = ($urandom_range(0, 19) == 0) ? 30 : $urandom_range(0, max_wait);
      run_instr(op, 1'($urandom_range(0, 1)), wf, wm, -1);
    end
  endtask

  initial begin
    ops = '{OP_R, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI, OP_ORI, OP_LUI, OP_LW, OP_SW};
    reset = 1'b0;
    opcode = '0;
    zero = 1'b0;
    mem_ready = 1'b0;
    sel = 1'b0;
    timeout_cfg = 16;
    do_reset();

    run_instr(OP_ADDI, 1'b0, 0, 0, -1);
    run_instr(OP_LW,   1'b0, 0, 3, -1);
    run_instr(OP_BEQ,  1'b1, 0, 0, -1);
    run_instr(OP_BEQ,  1'b0, 1, 0, -1);
    run_instr(OP_BNE,  1'b0, 0, 0, -1);
    run_instr(OP_BNE,  1'b1, 0, 0, -1);
    run_instr(OP_JAL,  1'b0, 0, 0, -1);
    run_instr(OP_J,    1'b0, 2, 0, -1);
    run_instr(OP_R,    1'b0, 0, 0, -1);
    run_instr(OP_ORI,  1'b0, 0, 0, -1);
    run_instr(OP_LUI,  1'b0, 0, 0, -1);
    run_instr(OP_SW,   1'b0, 0, 2, -1);
    run_instr(6'h3F,   1'b0, 0, 0, -1);
    run_instr(OP_LW,   1'b0, 15, 15, -1);
    run_instr(OP_ADDI, 1'b0, 16, 0, -1);
    run_random(40, 5);

    sel = 1'b1;
    timeout_cfg = 4;
    do_reset();
    run_instr(OP_ADDI, 1'b0, 100, 0, -1);
    run_instr(OP_LW,   1'b0, 3, 3, -1);
    run_instr(OP_SW,   1'b0, 0, 4, -1);
    run_instr(OP_SW,   1'b0, 0, 5, 1);
    run_instr(OP_R,    1'b0, 0, 0, -1);
    run_random(30, 5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
